img_pingpong_buffer: RTL and testbench
======================================

IMG_PINGPONG_BUFFER -- requirements
Module: img_pingpong_buffer

Interface
REQ-001 Parameter NPIX, default 256: pixels per frame (16x16 image).
REQ-002 Parameter ADR_W, default 9: read-address width; SHALL satisfy 2^ADR_W > NPIX.
REQ-003 Parameter BIAS_BYTE, default 8'hFF: byte returned at read address 0 (bias input).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 pix_valid  input  1  decimator has a pixel on pix_data.
REQ-007 pix_sof  input  1  qualifies the current pixel as frame pixel 0.
REQ-008 pix_data  input  8  unsigned pixel byte.
REQ-009 pix_ready  output  1  block accepts a pixel this cycle; transfer = pix_valid & pix_ready at a rising edge.
REQ-010 rd_addr  input  ADR_W  network read address (driven by the feedforward cycle counter).
REQ-011 rd_data  output  8  combinational read data.
REQ-012 img_valid  output  1  a complete frame is held in the read bank.
REQ-013 img_done  input  1  one-cycle pulse from the network: read bank released.
REQ-014 sof_err  output  1  one-cycle pulse: frame restarted before completion.

Function
REQ-015 Storage SHALL be two banks of NPIX bytes; one is the write bank, the other the read bank; the roles swap only as in REQ-022.
REQ-016 Write FSM SHALL have states IDLE, FILL, FULL; pix_ready SHALL be 1 in IDLE and FILL, 0 in FULL (Moore, no combinational path from inputs).
REQ-017 IDLE: transfer with pix_sof=1 -> write pix_data to write-bank index 0, count<=1, go FILL; transfer with pix_sof=0 -> pixel consumed and discarded, remain IDLE.
REQ-018 FILL: transfer with pix_sof=0 -> write at index count, count<=count+1.
REQ-019 FILL: transfer with pix_sof=1 -> write at index 0, count<=1, sof_err=1 for the next cycle, remain FILL; earlier partial data abandoned.
REQ-020 FILL: the transfer writing index NPIX-1 SHALL move the FSM to FULL; count SHALL never exceed NPIX.
REQ-021 No transfer in a cycle -> count and state unchanged (except FULL exit).
REQ-022 FULL: at each rising edge where (img_valid=0 or img_done=1), swap banks, set img_valid<=1, count<=0, go IDLE; otherwise remain FULL.
REQ-023 Minimum latency: img_valid rises at the rising edge after the edge that accepted the last pixel (FULL lasts >=1 cycle); pix_ready returns high in the same cycle.
REQ-024 img_done with no pending FULL SHALL clear img_valid at that edge; img_done while img_valid=0 SHALL be ignored.
REQ-025 img_done coincident with FULL: swap occurs, img_valid stays 1 (new frame), no idle cycle.
REQ-026 rd_data: rd_addr=0 -> BIAS_BYTE; 1<=rd_addr<=NPIX -> read bank[rd_addr-1]; rd_addr>NPIX -> 8'h00; independent of img_valid.
REQ-027 Read bank contents SHALL be stable while img_valid=1; writes never target the read bank.
REQ-028 Memory SHALL be plain registers/RAM with synchronous write; no reset of array contents.

Reset
REQ-029 On reset: state IDLE, count 0, write bank 0, read bank 1, img_valid 0, sof_err 0, pix_ready 1 (from IDLE).
REQ-030 Reset mid-frame SHALL abandon the partial frame and any held frame; first post-reset frame needs pix_sof.
REQ-031 After reset, rd_addr=0 SHALL still return BIAS_BYTE; other addresses unspecified until img_valid=1.

Verification
REQ-032 Reset, stream 256 pixels value=index[7:0] (sof on first), continuous valid -> pix_ready low 1 cycle, img_valid high 1 edge after last transfer; rd_addr 0/1/256/257 -> FF/00/FF/00.
REQ-033 Frame A held (no img_done), stream frame B fully -> pix_ready stays 0 after B's last pixel; pulse img_done -> img_valid stays 1, rd_addr=1 returns B pixel 0, pix_ready 1 next cycle.
REQ-034 Mid-frame (after 100 pixels) send pix_sof with 0x55 then 255 pixels -> sof_err pulses once, completed frame rd_addr=1 returns 0x55, img_valid rises after 256 post-restart pixels.
REQ-035 Pixels with pix_sof=0 in IDLE (10 pixels) then proper frame -> first 10 discarded, frame contents correct.
REQ-036 Assert reset at pixel 128 of frame 2 while frame 1 held -> img_valid 0 immediately, pix_ready 1, next full frame with sof yields img_valid=1 and correct data.
REQ-037 Random pix_valid gaps (50%) and random img_done timing over 20 frames -> scoreboard matches every frame, no lost/duplicated frame when consumer keeps up.

Source files
------------

// File: rtl/img_pingpong_if.sv
// img_pingpong_if: pixel-in / frame-read bundle between decimator, ping-pong buffer and network
interface img_pingpong_if #(
   parameter int ADR_W = 9
);
   logic             pix_valid;
   logic             pix_sof;
   logic [7:0]       pix_data;
   logic             pix_ready;
   logic [ADR_W-1:0] rd_addr;
   logic [7:0]       rd_data;
   logic             img_valid;
   logic             img_done;
   logic             sof_err;
   modport master (
      output pix_valid, pix_sof, pix_data, rd_addr, img_done,
      input  pix_ready, rd_data, img_valid, sof_err
   );
   modport slave (
      input  pix_valid, pix_sof, pix_data, rd_addr, img_done,
      output pix_ready, rd_data, img_valid, sof_err
   );
endinterface

// File: rtl/img_pingpong_buffer.sv
// img_pingpong_buffer: two-bank frame store; one bank fills from the decimator while the network reads the other
module img_pingpong_buffer #(
   parameter int         NPIX      = 256,
   parameter int         ADR_W     = 9,
   parameter logic [7:0] BIAS_BYTE = 8'hFF
) (
   input logic         clk,
   input logic         reset,
   img_pingpong_if.slave bus
);
   localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int CW = $clog2(NPIX + 1);
   localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2;
   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [CW-1:0]    nxt_count;
   logic             wr_bank;
   logic             xfer;
   logic             we;
   logic             swap;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic [ADR_W-1:0] rd_off;
   logic [7:0]       bank0 [0:NPIX-1];
   logic [7:0]       bank1 [0:NPIX-1];
   assign bus.pix_ready = state != FULL;
   assign xfer = bus.pix_valid & bus.pix_ready;
   // pixels without sof while IDLE are consumed but never stored
   assign we = xfer && (state == FILL || bus.pix_sof);
   assign swap = state == FULL && (!bus.img_valid || bus.img_done);
   assign nxt_count = bus.pix_sof ? CW'(1) : count + CW'(1);
   assign wr_idx = bus.pix_sof ? '0 : count[IW-1:0];
   // address 0 is the network's bias input, pixels live at 1..NPIX
   assign rd_off = bus.rd_addr - ADR_W'(1);
   assign rd_idx = rd_off[IW-1:0];
   assign bus.rd_data = (bus.rd_addr == '0) ? BIAS_BYTE :
                        (bus.rd_addr <= ADR_W'(NPIX)) ? (wr_bank ? bank0[rd_idx] : bank1[rd_idx]) : 8'h00;
   always_ff @(posedge clk)
      if (we)
         if (wr_bank) bank1[wr_idx] <= bus.pix_data;
         else bank0[wr_idx] <= bus.pix_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         wr_bank       <= 1'b0;
         bus.img_valid <= 1'b0;
         bus.sof_err   <= 1'b0;
      end else begin
         bus.sof_err   <= xfer && bus.pix_sof && state == FILL;
         bus.img_valid <= swap || (bus.img_valid && !bus.img_done);
         if (swap) begin
            wr_bank <= !wr_bank;
            count   <= '0;
            state   <= IDLE;
         end else if (we) begin
            count <= nxt_count;
            state <= (nxt_count == CW'(NPIX)) ? FULL : FILL;
         end
      end
endmodule

// File: tb/tb_img_pingpong_buffer.sv
// tb_img_pingpong_buffer: directed + random frames, scoreboarded against a frame-level byte-queue model
module tb_img_pingpong_buffer;
   localparam int NPIX  = 256;
   localparam int ADR_W = 9;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic auto_done = 1'b0;
   logic mon_done = 1'b0;
   logic dir_done = 1'b0;
   int checks = 0;
   int failures = 0;
   int exp_err = 0;
   int act_err = 0;
   int seen_frames = 0;
   logic [7:0] exp_q[$];
   logic [7:0] part[$];
   bit started = 0;
   img_pingpong_if #(.ADR_W(ADR_W)) bus();
   img_pingpong_buffer #(.NPIX(NPIX), .ADR_W(ADR_W), .BIAS_BYTE(8'hFF)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   assign bus.img_done = auto_done ? mon_done : dir_done;
   always #500 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // frame-level model: a frame is the sof pixel plus the next NPIX-1 accepted pixels
   task automatic model_xfer(input logic [7:0] d, input logic sof);
      if (sof) begin
         if (started) exp_err++;
         part.delete();
         part.push_back(d);
         started = 1;
      end else if (started) part.push_back(d);
      if (part.size() == NPIX) begin
         foreach (part[i]) exp_q.push_back(part[i]);
         part.delete();
         started = 0;
      end
   endtask
   task automatic model_reset();
      part.delete();
      exp_q.delete();
      started = 0;
   endtask
   task automatic send(input logic [7:0] d, input logic sof, input int gap);
      repeat (gap) begin
         bus.pix_valid = 1'b0;
         @(posedge clk); #10;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      bus.pix_sof   = sof;
      for (int n = 0; ; n++) begin
         logic acc;
         @(negedge clk);
         acc = bus.pix_ready;
         @(posedge clk); #10;
         if (acc) begin
            model_xfer(d, sof);
            break;
         end
         if (n == 2000) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      bus.pix_valid = 1'b0;
   endtask
   task automatic send_frame(input bit ramp, input bit gaps);
      for (int i = 0; i < NPIX; i++)
         send(ramp ? 8'(i) : 8'($urandom), i == 0, gaps ? int'($urandom_range(0, 1)) : 0);
   endtask
   task automatic pulse_done();
      dir_done = 1'b1;
      @(posedge clk); #10;
      dir_done = 1'b0;
   endtask
   task automatic wait_valid(input string name);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.img_valid) break;
      end
      chk(name, bus.img_valid, 1);
      @(posedge clk); #10;
   endtask
   task automatic check_frame();
      int bad;
      int fa;
      logic [7:0] fg;
      logic [7:0] fe;
      logic [7:0] e;
      seen_frames++;
      if (exp_q.size() < NPIX) begin
         chk("unexpected_frame", exp_q.size(), NPIX);
         return;
      end
      bad = 0;
      fa = 0;
      fg = 0;
      fe = 0;
      for (int a = 0; a <= NPIX + 1; a++) begin
         bus.rd_addr = ADR_W'(a);
         #1;
         e = (a == 0) ? 8'hFF : (a <= NPIX) ? exp_q[a-1] : 8'h00;
         if (bus.rd_data !== e) begin
            if (bad == 0) begin
               fa = a;
               fg = bus.rd_data;
               fe = e;
            end
            bad++;
         end
      end
      bus.rd_addr = '0;
      repeat (NPIX) void'(exp_q.pop_front());
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL frame%0d: %0d bad bytes, first at rd_addr %0d got %h expected %h", seen_frames, bad, fa, fg, fe);
      end
   endtask
   // monitor: reads each newly presented frame and, in auto mode, releases it after a random delay
   initial begin
      logic prev_valid;
      logic prev_done;
      bit held;
      int hold;
      prev_valid = 0;
      prev_done = 0;
      held = 0;
      hold = 0;
      bus.rd_addr = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 0;
            prev_done = 0;
            held = 0;
            mon_done = 0;
            continue;
         end
         if (bus.sof_err) act_err++;
         if (bus.img_valid && (!prev_valid || prev_done)) begin
            check_frame();
            held = 1;
            hold = $urandom_range(0, 6);
         end
         if (!bus.img_valid) held = 0;
         mon_done = 0;
         if (auto_done && held) begin
            if (hold == 0) begin
               mon_done = 1;
               held = 0;
            end else hold--;
         end
         #2;
         prev_valid = bus.img_valid;
         prev_done = bus.img_done;
      end
   end
   initial begin
      #60_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_data  = 8'h00;
      @(posedge clk); #10;
      chk("reset_pix_ready", bus.pix_ready, 1);
      chk("reset_img_valid", bus.img_valid, 0);
      chk("reset_sof_err", bus.sof_err, 0);
      chk("reset_bias", bus.rd_data, 8'hFF);
      @(posedge clk); #10;
      reset = 1'b0;
      @(posedge clk); #10;
      // ramp frame, continuous valid: one FULL cycle then img_valid
      send_frame(1, 0);
      @(negedge clk);
      chk("ramp_ready_low", bus.pix_ready, 0);
      chk("ramp_valid_not_yet", bus.img_valid, 0);
      @(negedge clk);
      chk("ramp_valid_rise", bus.img_valid, 1);
      chk("ramp_ready_back", bus.pix_ready, 1);
      @(posedge clk); #10;
      // second frame completes while first is held
      send_frame(0, 0);
      repeat (3) begin
         @(negedge clk);
         chk("held_ready_low", bus.pix_ready, 0);
      end
      chk("held_valid", bus.img_valid, 1);
      @(posedge clk); #10;
      pulse_done();
      @(negedge clk);
      chk("swap_valid_stays", bus.img_valid, 1);
      chk("swap_ready_high", bus.pix_ready, 1);
      @(posedge clk); #10;
      pulse_done();
      @(negedge clk);
      chk("done_clears_valid", bus.img_valid, 0);
      @(posedge clk); #10;
      pulse_done();
      @(negedge clk);
      chk("done_ignored", bus.img_valid, 0);
      @(posedge clk); #10;
      // restart mid-frame with 0x55
      for (int i = 0; i < 100; i++) send(8'($urandom), i == 0, 0);
      send(8'h55, 1, 0);
      @(negedge clk);
      chk("sof_err_pulse", bus.sof_err, 1);
      @(negedge clk);
      chk("sof_err_single", bus.sof_err, 0);
      @(posedge clk); #10;
      for (int i = 0; i < NPIX - 2; i++) send(8'($urandom), 0, 0);
      send(8'($urandom), 0, 0);
      @(negedge clk);
      chk("restart_valid_not_yet", bus.img_valid, 0);
      @(negedge clk);
      chk("restart_valid_rise", bus.img_valid, 1);
      @(posedge clk); #10;
      pulse_done();
      // stray pixels while idle are dropped
      for (int i = 0; i < 10; i++) send(8'($urandom), 0, 0);
      send_frame(0, 0);
      wait_valid("idle_discard_valid");
      pulse_done();
      // reset mid-frame while a frame is held
      send_frame(0, 0);
      wait_valid("pre_reset_valid");
      for (int i = 0; i < 128; i++) send(8'($urandom), i == 0, 0);
      reset = 1'b1;
      #1;
      chk("async_reset_valid", bus.img_valid, 0);
      chk("async_reset_ready", bus.pix_ready, 1);
      model_reset();
      @(posedge clk); #10;
      reset = 1'b0;
      chk("post_reset_bias", bus.rd_data, 8'hFF);
      @(posedge clk); #10;
      send_frame(0, 0);
      wait_valid("post_reset_valid");
      pulse_done();
      // random gaps, consumer releases frames on its own
      auto_done = 1'b1;
      repeat (20) send_frame(0, 1);
      for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
      #10;
      chk("drain_queue", exp_q.size(), 0);
      chk("frames_seen", seen_frames, 26);
      chk("sof_err_count", act_err, exp_err);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
